ss_adc_ctrl: RTL and testbench

SS_ADC_CTRL -- requirements
Module: ss_adc_ctrl

---
 rtl/ss_adc_pkg.sv | 16 +
 rtl/ss_adc_sync.sv | 56 +++++
 rtl/ss_adc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ss_adc_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_adc_pkg.sv
// Shared definitions for the single-slope ADC controller.
//   state_t      : controller state encoding
//   DEGLITCH_LEN : consecutive high synchronised samples that qualify a trip
//                  when the SS_ADC_DEGLITCH_EN build option is enabled
package ss_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DISCHARGE = 2'd1,
    ST_RAMP      = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam int unsigned DEGLITCH_LEN = 3;

endpackage

// File: rtl/ss_adc_sync.sv
// Per-channel comparator conditioning: two-flop synchroniser followed by the
// trip qualifier.
// Build option SS_ADC_DEGLITCH_EN: trip only after DEGLITCH_LEN consecutive
// high synchronised samples while qual_en is high; otherwise trip on the first
// high synchronised sample.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   async_in   : raw comparator output (asynchronous)
//   qual_en    : high while the ramp is running; trip is only raised then
//   trip       : qualified trip indication for the current cycle
module ss_adc_sync
  import ss_adc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic qual_en,
  output logic trip
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

`ifdef SS_ADC_DEGLITCH_EN
  localparam int RUN_W = $clog2(DEGLITCH_LEN);

  // Count of consecutive high samples seen in earlier ramp cycles; saturates
  // so trip stays asserted while the comparator remains high.
  logic [RUN_W-1:0] run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
    end else if (!qual_en || !sync_q) begin
      run_q <= '0;
    end else if (run_q != RUN_W'(DEGLITCH_LEN - 1)) begin
      run_q <= run_q + RUN_W'(1);
    end
  end

  assign trip = qual_en & sync_q & (run_q == RUN_W'(DEGLITCH_LEN - 1));
`else
  assign trip = qual_en & sync_q;
`endif

endmodule

// File: rtl/ss_adc_ctrl.sv
// Single-slope ADC conversion controller: discharges the ramp capacitor,
// runs the ramp counter and captures the count at which each channel's
// comparator trips. Results are offered on a valid/ready handshake.
// Build option SS_ADC_DEGLITCH_EN: comparator trips need DEGLITCH_LEN
// consecutive high samples; the count of the first of them is captured.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   start            : one-cycle conversion request (honoured in IDLE only)
//   comp_in          : asynchronous comparator outputs, one per channel
//   ramp_discharge   : high shorts the ramp capacitor
//   ramp_en          : high gates the ramp reference clock
//   busy             : high whenever not IDLE
//   result_data      : channel n at [n*CNT_W +: CNT_W]
//   overflow         : channel did not trip before the ramp ended
//   result_valid/ready : result handshake
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | waiting for start, capacitor held discharged
// ST_DISCHARGE | capacitor discharge for DISCHARGE_CYC cycles
// ST_RAMP      | ramp running, counter incrementing, trips captured
// ST_DONE      | result_valid high until result_ready
module ss_adc_ctrl
  import ss_adc_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int CNT_W         = 12,
  parameter int DISCHARGE_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CHANNELS-1:0]       comp_in,
  output logic                      ramp_discharge,
  output logic                      ramp_en,
  output logic                      busy,
  output logic [CHANNELS*CNT_W-1:0] result_data,
  output logic [CHANNELS-1:0]       overflow,
  output logic                      result_valid,
  input  logic                      result_ready
);

  localparam int DIS_W = (DISCHARGE_CYC > 1) ? $clog2(DISCHARGE_CYC) : 1;

  // A qualified trip is reported DEGLITCH_LEN-1 cycles after the first high
  // sample, so the captured count is rolled back by that amount.
`ifdef SS_ADC_DEGLITCH_EN
  localparam int unsigned LAG = DEGLITCH_LEN - 1;
`else
  localparam int unsigned LAG = 0;
`endif

  state_t                      state_q, state_d;
  logic [DIS_W-1:0]            dis_cnt_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        cnt_at_max;
  logic [CHANNELS-1:0]         trip;
  logic [CHANNELS-1:0]         lat_q;
  logic [CHANNELS*CNT_W-1:0]   res_q;
  logic [CHANNELS-1:0]         ovf_q;
  logic                        in_ramp;
  logic                        conv_go;

  assign cnt_at_max = (cnt_q == '1);
  assign in_ramp    = (state_q == ST_RAMP);
  assign conv_go    = (state_q == ST_IDLE) && start;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_sync
    ss_adc_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (comp_in[ch]),
      .qual_en  (in_ramp),
      .trip     (trip[ch])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_DISCHARGE;
      ST_DISCHARGE: if (dis_cnt_q == '0) state_d = ST_RAMP;
      ST_RAMP:      if ((&(lat_q | trip)) || cnt_at_max) state_d = ST_DONE;
      ST_DONE:      if (result_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b1;
    ramp_en        = 1'b0;
    ramp_discharge = 1'b1;
    result_valid   = 1'b0;
    unique case (state_q)
      ST_IDLE:      busy = 1'b0;
      ST_DISCHARGE: ;
      ST_RAMP: begin
        ramp_en        = 1'b1;
        ramp_discharge = 1'b0;
      end
      ST_DONE:      result_valid = 1'b1;
      default:      busy = 1'b0;
    endcase
  end

  // Discharge timer (down-counter, terminal count 0) and ramp counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dis_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (conv_go)
        dis_cnt_q <= DIS_W'(DISCHARGE_CYC - 1);
      else if (state_q == ST_DISCHARGE && dis_cnt_q != '0)
        dis_cnt_q <= dis_cnt_q - DIS_W'(1);

      if (state_q == ST_DISCHARGE)
        cnt_q <= '0;
      else if (in_ramp && !cnt_at_max)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Per-channel capture: first qualified trip wins; channels still open in
  // the all-ones cycle are forced to full scale with overflow set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      ovf_q <= '0;
      lat_q <= '0;
    end else if (conv_go) begin
      res_q <= '0;
      ovf_q <= '0;
      lat_q <= '0;
    end else if (in_ramp) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (!lat_q[ch]) begin
          if (trip[ch]) begin
            res_q[ch*CNT_W +: CNT_W] <= cnt_q - CNT_W'(LAG);
            ovf_q[ch]                <= 1'b0;
            lat_q[ch]                <= 1'b1;
          end else if (cnt_at_max) begin
            res_q[ch*CNT_W +: CNT_W] <= '1;
            ovf_q[ch]                <= 1'b1;
            lat_q[ch]                <= 1'b1;
          end
        end
      end
    end
  end

  assign result_data = res_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ss_adc_ctrl.sv
module tb_ss_adc_ctrl;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int D    = 12;
  localparam int MAXV = (1 << W) - 1;
  localparam int WMAX = 320;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            result_ready;
  logic            ramp_discharge;
  logic            ramp_en;
  logic            busy;
  logic            result_valid;
  logic [CH-1:0]   comp_in;
  logic [CH-1:0]   overflow;
  logic [CH*W-1:0] result_data;

  ss_adc_ctrl #(.CHANNELS(CH), .CNT_W(W), .DISCHARGE_CYC(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .comp_in        (comp_in),
    .ramp_discharge (ramp_discharge),
    .ramp_en        (ramp_en),
    .busy           (busy),
    .result_data    (result_data),
    .overflow       (overflow),
    .result_valid   (result_valid),
    .result_ready   (result_ready)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Comparator waveform for one conversion, indexed by cycle offset from the
  // start cycle. The synchronised value seen at ramp count k is wave[D-1+k].
  logic [CH-1:0]   wave [WMAX];
  int              m_res [CH];
  logic [CH-1:0]   m_ovf;
  int              m_last;
  logic [CH*W-1:0] held_data;
  logic [CH-1:0]   held_ovf;

  logic            e_busy, e_ramp_en, e_disch, e_valid, e_chk_res;
  logic            chk_on = 1'b0;
  logic [CH*W-1:0] e_data;
  logic [CH-1:0]   e_ovf;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
    end
  endtask

  task automatic compare_all();
    cmp("busy", 64'(busy), 64'(e_busy));
    cmp("ramp_en", 64'(ramp_en), 64'(e_ramp_en));
    cmp("ramp_discharge", 64'(ramp_discharge), 64'(e_disch));
    cmp("result_valid", 64'(result_valid), 64'(e_valid));
    if (e_chk_res) begin
      cmp("result_data", 64'(result_data), 64'(e_data));
      cmp("overflow", 64'(overflow), 64'(e_ovf));
    end
  endtask

  always @(negedge clk) if (chk_on) compare_all();

  function automatic logic [CH*W-1:0] model_data();
    logic [CH*W-1:0] v;
    v = '0;
    for (int ch = 0; ch < CH; ch++) v[ch*W +: W] = W'(m_res[ch]);
    return v;
  endfunction

  task automatic exp_idle();
    e_busy = 0; e_ramp_en = 0; e_disch = 1; e_valid = 0;
    e_chk_res = 1; e_data = held_data; e_ovf = held_ovf;
  endtask

  task automatic exp_discharge();
    e_busy = 1; e_ramp_en = 0; e_disch = 1; e_valid = 0;
    e_chk_res = 1; e_data = '0; e_ovf = '0;
  endtask

  task automatic exp_ramp();
    e_busy = 1; e_ramp_en = 1; e_disch = 0; e_valid = 0;
    e_chk_res = 0; e_data = '0; e_ovf = '0;
  endtask

  task automatic exp_done();
    e_busy = 1; e_ramp_en = 0; e_disch = 1; e_valid = 1;
    e_chk_res = 1; e_data = model_data(); e_ovf = m_ovf;
  endtask

  task automatic clear_wave();
    foreach (wave[i]) wave[i] = '0;
  endtask

  // Comparator high so that the synchronised copy is high for ramp counts
  // from_k..to_k (negative from_k reaches back before the start pulse).
  task automatic set_high(input int ch, input int from_k, input int to_k);
    for (int i = D - 1 + from_k; i <= D - 1 + to_k; i++)
      if (i >= 0 && i < WMAX) wave[i][ch] = 1'b1;
  endtask

  function automatic bit sync_at(input int ch, input int k);
    return wave[D - 1 + k][ch];
  endfunction

  // Reference: scan the ramp counts for each channel's first qualifying trip.
  task automatic run_model();
    m_last = 0;
    m_ovf  = '0;
    for (int ch = 0; ch < CH; ch++) begin
      int end_k;
      bit found;
      found = 0;
      end_k = MAXV;
      m_res[ch] = MAXV;
      for (int k = 0; k <= MAXV && !found; k++) begin
`ifdef SS_ADC_DEGLITCH_EN
        if (k >= 2 && sync_at(ch, k) && sync_at(ch, k - 1) && sync_at(ch, k - 2)) begin
          found = 1; m_res[ch] = k - 2; end_k = k;
        end
`else
        if (sync_at(ch, k)) begin
          found = 1; m_res[ch] = k; end_k = k;
        end
`endif
      end
      if (!found) m_ovf[ch] = 1'b1;
      if (end_k > m_last) m_last = end_k;
    end
  endtask

  task automatic gap(input int n, input logic [CH-1:0] val);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      comp_in = val;
      result_ready = 1'($urandom_range(0, 1));
      exp_idle();
      @(posedge clk); #1;
    end
  endtask

  // One conversion: start at offset 0, DISCHARGE at 1..D, RAMP count k at
  // D+1+k, DONE from D+2+last until the handshake at D+2+last+rd.
  task automatic run_conv(input int rd, input bit force_hs, input int rst_at);
    int done_o, hs_o;
    run_model();
    done_o = D + 2 + m_last;
    hs_o   = done_o + rd;
    for (int o = 0; o <= hs_o + 1; o++) begin
      comp_in = wave[(o < WMAX) ? o : WMAX - 1];
      if (o == 0)        start = 1'b1;
      else if (o > hs_o) start = 1'b0;
      else               start = (force_hs && o >= done_o) || ($urandom_range(0, 15) == 0);
      if (o == hs_o)                    result_ready = 1'b1;
      else if (o < done_o || o > hs_o)  result_ready = 1'($urandom_range(0, 1));
      else                              result_ready = 1'b0;
      if (o == 0 || o > hs_o) exp_idle();
      else if (o <= D)        exp_discharge();
      else if (o < done_o)    exp_ramp();
      else                    exp_done();
      if (o == hs_o) begin
        held_data = model_data();
        held_ovf  = m_ovf;
      end
      if (o == rst_at) begin
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        held_data = '0;
        held_ovf  = '0;
        exp_idle();
        #1;
        compare_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        gap(10, '0);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    comp_in = '0;
    result_ready = 1'b0;
    held_data = '0;
    held_ovf  = '0;
    exp_idle();
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(3, '0);

    // Staggered trips at counts 10/50/100/200.
    clear_wave();
    set_high(0, 10, 999); set_high(1, 50, 999); set_high(2, 100, 999); set_high(3, 200, 999);
    run_model();
    cmp("t1_res0", 64'(m_res[0]), 64'd10);
    cmp("t1_res1", 64'(m_res[1]), 64'd50);
    cmp("t1_res2", 64'(m_res[2]), 64'd100);
    cmp("t1_res3", 64'(m_res[3]), 64'd200);
    cmp("t1_ovf", 64'(m_ovf), 64'h0);
    cmp("t1_last", 64'(m_last), 64'd200);
    run_conv(2, 1'b0, -1);
    gap(2, '0);

    // Channel 2 never trips.
    clear_wave();
    set_high(0, 10, 999); set_high(1, 20, 999); set_high(3, 40, 999);
    run_model();
    cmp("t2_res2", 64'(m_res[2]), 64'd255);
    cmp("t2_ovf", 64'(m_ovf), 64'h4);
    cmp("t2_last", 64'(m_last), 64'd255);
    run_conv(1, 1'b0, -1);
    gap(2, '0);

    // Channel 1 comparator already high before start.
    gap(3, 4'b0010);
    clear_wave();
    set_high(1, -(D - 1), 999); set_high(0, 5, 999); set_high(2, 7, 999); set_high(3, 9, 999);
    run_model();
    cmp("t3_res1", 64'(m_res[1]), 64'd0);
    run_conv(0, 1'b0, -1);
    gap(2, '0);

    // Ready withheld 20 cycles in DONE while start is pulsed.
    clear_wave();
    set_high(0, 20, 999); set_high(1, 21, 999); set_high(2, 22, 999); set_high(3, 23, 999);
    run_conv(20, 1'b1, -1);
    gap(2, '0);

    // Reset mid-ramp.
    clear_wave();
    set_high(0, 100, 999); set_high(1, 101, 999); set_high(2, 102, 999); set_high(3, 103, 999);
    run_conv(0, 1'b0, D + 1 + 50);

    // Two-sample glitch at count 30, solid high from count 80.
    clear_wave();
    for (int ch = 0; ch < CH; ch++) begin
      set_high(ch, 30, 31);
      set_high(ch, 80, 999);
    end
    run_model();
`ifdef SS_ADC_DEGLITCH_EN
    cmp("t6_res0", 64'(m_res[0]), 64'd80);
`else
    cmp("t6_res0", 64'(m_res[0]), 64'd30);
`endif
    cmp("t6_ovf", 64'(m_ovf), 64'h0);
    run_conv(1, 1'b0, -1);
    gap(2, '0);

    // Randomised conversions.
    for (int n = 0; n < 30; n++) begin
      clear_wave();
      for (int ch = 0; ch < CH; ch++) begin
        int mode, rise, ng;
        mode = $urandom_range(0, 9);
        if (mode == 0)      rise = -(D - 1);
        else if (mode == 1) rise = 300;
        else                rise = $urandom_range(0, 270);
        ng = $urandom_range(0, 3);
        for (int g = 0; g < ng; g++) begin
          int gk, len;
          gk  = $urandom_range(0, (rise > 0) ? rise : 0);
          len = $urandom_range(1, 2);
          set_high(ch, gk, gk + len - 1);
        end
        set_high(ch, rise, 999);
      end
      run_conv($urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
      gap($urandom_range(1, 4), CH'($urandom));
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
